// File: rtl/bitlet_accumulator_32_if.sv
// bitlet_accumulator_32_if: activation load, per-plane lane selects and the
// result handshake between the bitlet scheduler side (master) and the
// accumulator (slave).
//
// Handshake: result is offered with out_valid=1; result and out_valid stay
// stable until the cycle in which out_ready=1 is also seen, and the transfer
// completes at that rising edge. out_valid never depends on out_ready.
interface bitlet_accumulator_32_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 32,
  parameter int ACT_WIDTH     = 8,
  parameter int ACC_WIDTH     = 24,
  parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH)
);
  logic                                     load_act;
  logic [VEC_LENGTH-1:0][ACT_WIDTH-1:0]     act_in;
  logic [VEC_LENGTH-1:0]                    sign_in;
  logic                                     start;
  logic [DATA_WIDTH-1:0][MUX_SEL_WIDTH-1:0] act_sel;
  logic [DATA_WIDTH-1:0]                    act_val;
  logic                                     busy;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [ACC_WIDTH-1:0]                     result;

  modport master (
    output load_act, act_in, sign_in, start, act_sel, act_val, out_ready,
    input  busy, out_valid, result
  );

  modport slave (
    input  load_act, act_in, sign_in, start, act_sel, act_val, out_ready,
    output busy, out_valid, result
  );
endinterface

// File: rtl/bitlet_accumulator_32.sv
// bitlet_accumulator_32: consumer side of the bitlet weight scheduler.
// Each ACCUM cycle one lane index per weight bit-plane selects an activation
// from the local bank; the plane-weighted, sign-corrected sum goes to stage 1
// and is added into the accumulator one cycle later. An all-invalid sample
// closes the dot product (DRAIN), after which the result is offered in DONE.
// Optional feature: define BITLET_ACC_SAT_EN to saturate the stage-1 sum and
// the accumulator instead of wrapping mod 2^ACC_WIDTH.
module bitlet_accumulator_32 #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 32,
  parameter int ACT_WIDTH     = 8,
  parameter int ACC_WIDTH     = 24,
  parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_comp,
  bitlet_accumulator_32_if.slave bus,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

`ifdef BITLET_ACC_SAT_EN
  // Plane sum is formed wide enough that it cannot wrap before clamping.
  localparam int RAW_W = ACT_WIDTH + DATA_WIDTH + 4;
  localparam int SUM_W = (RAW_W > ACC_WIDTH) ? RAW_W : ACC_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`else
  localparam int SUM_W = ACC_WIDTH;
`endif

  state_t                               state_q, state_d;
  logic signed [ACC_WIDTH-1:0]          acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]          stage1_q, stage1_d;
  logic [VEC_LENGTH-1:0][ACT_WIDTH-1:0] act_bank_q;
  logic [VEC_LENGTH-1:0]                sign_bank_q;

  logic signed [SUM_W-1:0]              plane_sum;
  logic signed [SUM_W-1:0]              term;
  logic [MUX_SEL_WIDTH-1:0]             lane;
  logic                                 any_valid;
  logic                                 bank_wr_en;
  logic signed [ACC_WIDTH-1:0]          stage1_next;
  logic signed [ACC_WIDTH-1:0]          acc_sum;

  assign any_valid  = |bus.act_val;
  assign bank_wr_en = bus.load_act && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Sum of the per-plane terms: selected activation, sign-extended, shifted by
  // the plane significance and negated for negative weights.
  always_comb begin
    plane_sum = '0;
    term      = '0;
    lane      = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      lane = bus.act_sel[j];
      term = SUM_W'($signed(act_bank_q[lane]));
      term = term <<< j;
      if (sign_bank_q[lane]) begin
        term = -term;
      end
      if (bus.act_val[j]) begin
        plane_sum = plane_sum + term;
      end
    end
  end

`ifdef BITLET_ACC_SAT_EN
  logic signed [ACC_WIDTH:0] acc_wide;

  assign acc_wide = {acc_q[ACC_WIDTH-1], acc_q} + {stage1_q[ACC_WIDTH-1], stage1_q};

  // Clamp the wide plane sum into the accumulator range.
  always_comb begin
    if (plane_sum > SUM_W'(ACC_MAX)) begin
      stage1_next = ACC_MAX;
    end else if (plane_sum < SUM_W'(ACC_MIN)) begin
      stage1_next = ACC_MIN;
    end else begin
      stage1_next = plane_sum[ACC_WIDTH-1:0];
    end
  end

  // Saturating stage-2 add: overflow shows as disagreeing top two bits.
  always_comb begin
    if (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]) begin
      acc_sum = acc_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_sum = acc_wide[ACC_WIDTH-1:0];
    end
  end
`else
  assign stage1_next = plane_sum;
  assign acc_sum     = acc_q + stage1_q;
`endif

  // Next-state and datapath control; en_comp only gates ACCUM and DRAIN.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    stage1_d = stage1_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          stage1_d = '0;
          state_d  = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (en_comp) begin
          stage1_d = stage1_next;
          acc_d    = acc_sum;
          if (!any_valid) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (en_comp) begin
          acc_d   = acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, stage-1 and accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      stage1_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      stage1_q <= stage1_d;
    end
  end

  // Activation/sign bank; writable only while no dot product is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_bank_q  <= '0;
      sign_bank_q <= '0;
    end else if (bank_wr_en) begin
      act_bank_q  <= bus.act_in;
      sign_bank_q <= bus.sign_in;
    end
  end

  assign bus.busy      = (state_q == S_ACCUM) || (state_q == S_DRAIN);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = acc_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_bitlet_accumulator_32.sv
// tb_bitlet_accumulator_32: directed bench for bitlet_accumulator_32.
// A second instance with ACC_WIDTH=12 covers the overflow case.
module tb_bitlet_accumulator_32;

  logic clk;
  logic reset;
  logic en_comp;
  logic [1:0] state_main;
  logic [1:0] state_12;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat;
  logic [31:0] exp_q[$];

  bitlet_accumulator_32_if #(.ACC_WIDTH(24)) bus();
  bitlet_accumulator_32_if #(.ACC_WIDTH(12)) bus12();

  bitlet_accumulator_32 #(.ACC_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .en_comp(en_comp), .bus(bus), .state_o(state_main)
  );

  bitlet_accumulator_32 #(.ACC_WIDTH(12)) dut12 (
    .clk(clk), .reset(reset), .en_comp(en_comp), .bus(bus12), .state_o(state_12)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic load(input int ln, input logic [7:0] val, input logic sgn);
    bus.act_in[ln]  = val;
    bus.sign_in[ln] = sgn;
    bus.load_act    = 1'b1;
    tick();
    bus.load_act    = 1'b0;
  endtask

  task automatic set_sel(input int p, input int ln);
    bus.act_sel[p] = 5'(ln);
  endtask

  task automatic wait_valid(input int max_cyc);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check("valid_timeout", bus.out_valid, 1);
  endtask

  task automatic check_result(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(tag, $signed(bus.result), e);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hs_valid_low", bus.out_valid, 0);
    check("hs_idle", state_main, 0);
  endtask

  // Start, one cycle with plane0/plane2 on lane 3, one empty cycle, then wait.
  task automatic run_basic(output int l);
    int t0;
    bus.start = 1'b1;
    tick();
    t0 = cyc;
    bus.start = 1'b0;
    bus.act_sel = '0;
    set_sel(0, 3);
    set_sel(2, 3);
    bus.act_val = 8'h05;
    tick();
    check("basic_busy", bus.busy, 1);
    bus.act_val = 8'h00;
    tick();
    check("basic_drain_state", state_main, 2);
    check("basic_drain_nov", bus.out_valid, 0);
    wait_valid(10);
    l = cyc - t0;
  endtask

  initial begin
    int t0;
    logic signed [31:0] ov_exp;
    reset = 1'b1;
    en_comp = 1'b1;
    bus.load_act = 1'b0; bus.act_in = '0; bus.sign_in = '0; bus.start = 1'b0;
    bus.act_sel = '0; bus.act_val = '0; bus.out_ready = 1'b0;
    bus12.load_act = 1'b0; bus12.act_in = '0; bus12.sign_in = '0; bus12.start = 1'b0;
    bus12.act_sel = '0; bus12.act_val = '0; bus12.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_result", $signed(bus.result), 0);
    check("rst_state", state_main, 0);

    // Basic: 5*1 + 5*4 = 25, valid 3 edges after start
    load(3, 8'd5, 1'b0);
    exp_q.push_back(32'd25);
    run_basic(lat);
    check("basic_latency", lat, 3);
    check_result("basic_result");
    handshake();

    // Signed: -(-3)<<7 + 7<<1 + 7 = 405
    load(0, 8'hFD, 1'b1);
    load(31, 8'd7, 1'b0);
    exp_q.push_back(32'd405);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.act_sel = '0;
    set_sel(7, 0);
    set_sel(1, 31);
    bus.act_val = 8'h82;
    tick();
    bus.act_sel = '0;
    set_sel(0, 31);
    bus.act_val = 8'h01;
    tick();
    bus.act_val = 8'h00;
    tick();
    wait_valid(10);
    check_result("signed_result");
    handshake();

    // Stall: 3 frozen cycles with junk selects that must not be sampled
    exp_q.push_back(32'd25);
    bus.start = 1'b1;
    tick();
    t0 = cyc;
    bus.start = 1'b0;
    bus.act_sel = '0;
    set_sel(0, 3);
    set_sel(2, 3);
    bus.act_val = 8'h05;
    tick();
    set_sel(1, 3);
    bus.act_val = 8'h07;
    en_comp = 1'b0;
    tick();
    tick();
    tick();
    check("stall_state", state_main, 1);
    check("stall_acc_frozen", $signed(bus.result), 0);
    en_comp = 1'b1;
    bus.act_val = 8'h00;
    tick();
    wait_valid(10);
    check("stall_latency", cyc - t0, 6);
    check_result("stall_result");
    handshake();

    // Backpressure: result held, start ignored, bank reload honoured in DONE
    exp_q.push_back(32'd25);
    run_basic(lat);
    check_result("bp_first_result");
    bus.act_in[3] = 8'd9;
    for (int i = 0; i < 5; i++) begin
      bus.start    = (i % 2 == 0);
      bus.load_act = (i % 2 == 1);
      tick();
      check("bp_result_stable", $signed(bus.result), 25);
      check("bp_valid_held", bus.out_valid, 1);
      check("bp_not_busy", bus.busy, 0);
    end
    bus.load_act  = 1'b0;
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_hs_valid_low", bus.out_valid, 0);
    check("bp_start_ignored", bus.busy, 0);
    exp_q.push_back(32'd45);
    run_basic(lat);
    check_result("bp_new_act_result");
    handshake();

    // Reset during ACCUM aborts; bank cleared so next run gives 0
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.act_val = 8'h05;
    tick();
    tick();
    check("pre_rst_acc", $signed(bus.result), 45);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.act_val = 8'h00;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_result", $signed(bus.result), 0);
    exp_q.push_back(32'd0);
    bus.start = 1'b1;
    tick();
    t0 = cyc;
    bus.start = 1'b0;
    tick();
    wait_valid(10);
    check("empty_latency", cyc - t0, 2);
    check_result("empty_result");
    handshake();

    // Overflow on the 12-bit instance: 4 cycles of 127*255
`ifdef BITLET_ACC_SAT_EN
    ov_exp = 32'sd2047;
`else
    ov_exp = -32'sd1532;
`endif
    bus12.act_in[0]  = 8'd127;
    bus12.sign_in[0] = 1'b0;
    bus12.load_act   = 1'b1;
    tick();
    bus12.load_act   = 1'b0;
    bus12.start      = 1'b1;
    tick();
    bus12.start      = 1'b0;
    bus12.act_sel    = '0;
    bus12.act_val    = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    bus12.act_val    = 8'h00;
    tick();
    for (int i = 0; i < 10 && bus12.out_valid !== 1'b1; i++) tick();
    check("ov_valid", bus12.out_valid, 1);
    check("ov_result", $signed(bus12.result), ov_exp);
    bus12.out_ready = 1'b1;
    tick();
    bus12.out_ready = 1'b0;
    check("ov_hs_idle", state_12, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
